// File: rtl/md_div_unit_pkg.sv
// Shared multiply/divide decode constants and divider FSM encodings.
package md_div_unit_pkg;

   localparam int MD_OP_WIDTH = 2;
   localparam logic [MD_OP_WIDTH-1:0] MD_OP_MUL = 2'd0;
   localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIV = 2'd1;
   localparam logic [MD_OP_WIDTH-1:0] MD_OP_REM = 2'd2;

   localparam int MD_OUT_SEL_WIDTH = 2;
   localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_LO   = 2'd0;
   localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_HI   = 2'd1;
   localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_HISU = 2'd2;
   localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_REM  = 2'd3;

   localparam int DIV_XLEN  = 32;
   localparam int DIV_CNT_W = $clog2(DIV_XLEN);

   typedef enum logic [1:0] {
      DIV_ST_IDLE = 2'd0,
      DIV_ST_BUSY = 2'd1,
      DIV_ST_DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/md_div_unit_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module md_div_unit_div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem_in,
   input  logic            dvd_bit,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_out,
   output logic            q_bit
);

   logic [XLEN:0]   shifted;
   logic [XLEN-1:0] diff;

   assign shifted = {rem_in, dvd_bit};
   // rem_in < divisor, so a successful subtraction always fits in XLEN bits.
   assign diff    = shifted[XLEN-1:0] - divisor;
   assign q_bit   = (shifted >= {1'b0, divisor});
   assign rem_out = q_bit ? diff : shifted[XLEN-1:0];

endmodule

// File: rtl/md_div_unit.sv
// Multi-cycle radix-2 restoring divide/remainder unit (DIV/DIVU/REM/REMU), one op in flight.
module md_div_unit
   import md_div_unit_pkg::*;
#(
   parameter int XLEN  = DIV_XLEN,
   parameter int TAG_W = 6
) (
   input  logic                        clk,
   input  logic                        reset_x,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [MD_OP_WIDTH-1:0]      req_op,
   input  logic                        req_in_1_signed,
   input  logic                        req_in_2_signed,
   input  logic [MD_OUT_SEL_WIDTH-1:0] req_out_sel,
   input  logic [XLEN-1:0]             req_src1,
   input  logic [XLEN-1:0]             req_src2,
   input  logic [TAG_W-1:0]            req_tag,
   input  logic                        kill,
   output logic                        resp_valid,
   input  logic                        resp_ready,
   output logic [XLEN-1:0]             resp_result,
   output logic [TAG_W-1:0]            resp_tag
);

   div_state_t           state, state_nxt;
   logic                 valid_nxt;
   logic                 accept;
   logic                 src1_neg, src2_neg, src2_zero, req_want_rem;
   logic [XLEN-1:0]      abs1, abs2;
   logic [XLEN-1:0]      rem_q, dvd_q, dsr_q, tag_unused_guard;
   logic                 sign_q, sign_r, want_rem_q;
   logic [TAG_W-1:0]     tag_q;
   logic [DIV_CNT_W-1:0] cnt_q;
   logic [XLEN-1:0]      rem_nxt, quo_final, quo_fix, rem_fix;
   logic                 q_bit;

   assign req_ready    = (state == DIV_ST_IDLE);
   assign accept       = req_valid && req_ready && !kill;
   assign src1_neg     = req_in_1_signed & req_src1[XLEN-1];
   assign src2_neg     = req_in_2_signed & req_src2[XLEN-1];
   assign src2_zero    = (req_src2 == '0);
   assign req_want_rem = (req_out_sel == MD_OUT_REM);
   assign abs1         = src1_neg ? -req_src1 : req_src1;
   assign abs2         = src2_neg ? -req_src2 : req_src2;
   assign tag_unused_guard = '0;

   md_div_unit_div_step #(.XLEN(XLEN)) u_div_step (
      .rem_in  (rem_q),
      .dvd_bit (dvd_q[XLEN-1]),
      .divisor (dsr_q),
      .rem_out (rem_nxt),
      .q_bit   (q_bit)
   );

   // Quotient bits enter at the LSB as dividend bits leave at the MSB.
   assign quo_final = {dvd_q[XLEN-2:0], q_bit};
   assign quo_fix   = sign_q ? -quo_final : quo_final;
   assign rem_fix   = sign_r ? -rem_nxt   : rem_nxt;

   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         state      <= DIV_ST_IDLE;
         resp_valid <= 1'b0;
      end else begin
         state      <= state_nxt;
         resp_valid <= valid_nxt;
      end
   end

   // resp_valid trails entry into DONE by one cycle; the result is already stable then.
   always_comb begin
      state_nxt = state;
      valid_nxt = 1'b0;
      case (state)
         DIV_ST_IDLE: if (accept) state_nxt = src2_zero ? DIV_ST_DONE : DIV_ST_BUSY;
         DIV_ST_BUSY: if (cnt_q == '0) state_nxt = DIV_ST_DONE;
         DIV_ST_DONE: begin
            if (resp_valid && resp_ready) state_nxt = DIV_ST_IDLE;
            else                          valid_nxt = 1'b1;
         end
         default:     state_nxt = DIV_ST_IDLE;
      endcase
      if (kill) begin
         state_nxt = DIV_ST_IDLE;
         valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         rem_q       <= '0;
         dvd_q       <= '0;
         dsr_q       <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         want_rem_q  <= 1'b0;
         tag_q       <= '0;
         cnt_q       <= '0;
         resp_result <= '0;
         resp_tag    <= '0;
      end else if (accept) begin
         rem_q      <= tag_unused_guard;
         dvd_q      <= abs1;
         dsr_q      <= abs2;
         sign_q     <= src1_neg ^ src2_neg;
         sign_r     <= src1_neg;
         want_rem_q <= req_want_rem;
         tag_q      <= req_tag;
         cnt_q      <= DIV_CNT_W'(XLEN-1);
         if (src2_zero) begin
            resp_result <= req_want_rem ? req_src1 : '1;
            resp_tag    <= req_tag;
         end
      end else if (state == DIV_ST_BUSY && !kill) begin
         rem_q <= rem_nxt;
         dvd_q <= quo_final;
         cnt_q <= cnt_q - DIV_CNT_W'(1);
         if (cnt_q == '0) begin
            resp_result <= want_rem_q ? rem_fix : quo_fix;
            resp_tag    <= tag_q;
         end
      end
   end

   op_not_mul: assert property (@(posedge clk) disable iff (!reset_x)
      req_valid |-> (req_op != MD_OP_MUL));

endmodule

// File: tb/tb_md_div_unit.sv
// Self-checking bench for md_div_unit: directed divide/remainder cases, kill, backpressure, reset.
module tb_md_div_unit;
   import md_div_unit_pkg::*;

   localparam int XLEN  = 32;
   localparam int TAG_W = 6;

   logic                        clk;
   logic                        reset_x;
   logic                        req_valid;
   logic                        req_ready;
   logic [MD_OP_WIDTH-1:0]      req_op;
   logic                        req_in_1_signed;
   logic                        req_in_2_signed;
   logic [MD_OUT_SEL_WIDTH-1:0] req_out_sel;
   logic [XLEN-1:0]             req_src1;
   logic [XLEN-1:0]             req_src2;
   logic [TAG_W-1:0]            req_tag;
   logic                        kill;
   logic                        resp_valid;
   logic                        resp_ready;
   logic [XLEN-1:0]             resp_result;
   logic [TAG_W-1:0]            resp_tag;

   int n_tests = 0;
   int n_fail  = 0;
   logic [XLEN-1:0]  exp_q[$];
   logic [TAG_W-1:0] exp_tag_q[$];

   md_div_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clk             (clk),
      .reset_x         (reset_x),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_op          (req_op),
      .req_in_1_signed (req_in_1_signed),
      .req_in_2_signed (req_in_2_signed),
      .req_out_sel     (req_out_sel),
      .req_src1        (req_src1),
      .req_src2        (req_src2),
      .req_tag         (req_tag),
      .kill            (kill),
      .resp_valid      (resp_valid),
      .resp_ready      (resp_ready),
      .resp_result     (resp_result),
      .resp_tag        (resp_tag)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
      $fatal(1, "watchdog");
   end

   // Reference: 64-bit signed arithmetic, truncating division, spec'd divide-by-zero results.
   function automatic logic [XLEN-1:0] model(input logic s1, input logic s2, input logic want_rem,
                                             input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      longint da, db, q, r;
      if (b == '0) return want_rem ? a : 32'hFFFF_FFFF;
      da = s1 ? longint'($signed(a)) : longint'(a);
      db = s2 ? longint'($signed(b)) : longint'(b);
      q  = da / db;
      r  = da % db;
      return want_rem ? r[XLEN-1:0] : q[XLEN-1:0];
   endfunction

   // ---------------- driver tasks ----------------
   task automatic issue(input logic want_rem, input logic s1, input logic s2,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [TAG_W-1:0] tag, input bit push);
      int n = 0;
      while (req_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      n_tests++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL issue_ready: req_ready=%b, required 1 within 100 cycles", req_ready);
      end
      req_valid       = 1'b1;
      req_op          = want_rem ? MD_OP_REM : MD_OP_DIV;
      req_out_sel     = want_rem ? MD_OUT_REM : MD_OUT_LO;
      req_in_1_signed = s1;
      req_in_2_signed = s2;
      req_src1        = a;
      req_src2        = b;
      req_tag         = tag;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      if (push) begin
         exp_q.push_back(model(s1, s2, want_rem, a, b));
         exp_tag_q.push_back(tag);
      end
   endtask

   task automatic run_op(input string name, input logic want_rem, input logic s1, input logic s2,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [TAG_W-1:0] tag, input int hold);
      logic [XLEN-1:0]  er;
      logic [TAG_W-1:0] et;
      int n;
      int exp_lat;
      issue(want_rem, s1, s2, a, b, tag, 1'b1);
      exp_lat = (b == '0) ? 1 : XLEN + 1;
      n = 0;
      while (resp_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      er = exp_q.pop_front();
      et = exp_tag_q.pop_front();
      n_tests++;
      if (resp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_timeout: resp_valid=%b after %0d cycles, required 1", name, resp_valid, n);
         return;
      end
      n_tests++;
      if (n != exp_lat) begin
         n_fail++;
         $display("FAIL %s_latency: got %0d cycles, required %0d", name, n, exp_lat);
      end
      n_tests++;
      if (resp_result !== er) begin
         n_fail++;
         $display("FAIL %s_result: got 0x%08h, required 0x%08h", name, resp_result, er);
      end
      n_tests++;
      if (resp_tag !== et) begin
         n_fail++;
         $display("FAIL %s_tag: got %0d, required %0d", name, resp_tag, et);
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         n_tests++;
         if (resp_valid !== 1'b1 || resp_result !== er || resp_tag !== et || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_hold[%0d]: valid=%b result=0x%08h tag=%0d ready=%b, required 1 0x%08h %0d 0",
                     name, i, resp_valid, resp_result, resp_tag, req_ready, er, et);
         end
      end
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      n_tests++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_handshake: resp_valid=%b req_ready=%b, required 0 1", name, resp_valid, req_ready);
      end
   endtask

   task automatic watch_quiet(input string name, input int cycles);
      bit seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (resp_valid === 1'b1) seen = 1'b1;
      end
      n_tests++;
      if (seen) begin
         n_fail++;
         $display("FAIL %s_quiet: resp_valid=1 seen, required 0 for %0d cycles", name, cycles);
      end
   endtask

   // ---------------- test tasks ----------------
   task automatic test_reset();
      reset_x = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_result !== '0 || resp_tag !== '0) begin
         n_fail++;
         $display("FAIL reset: ready=%b valid=%b result=0x%08h tag=%0d, required 1 0 0 0",
                  req_ready, resp_valid, resp_result, resp_tag);
      end
      reset_x = 1'b1;
      @(negedge clk);
      n_tests++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: ready=%b valid=%b, required 1 0", req_ready, resp_valid);
      end
   endtask

   task automatic test_unsigned();
      run_op("divu_100_7", 1'b0, 1'b0, 1'b0, 32'd100, 32'd7, 6'd5, 0);
      run_op("remu_100_7", 1'b1, 1'b0, 1'b0, 32'd100, 32'd7, 6'd6, 0);
      run_op("divu_big",   1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd3, 6'd7, 0);
   endtask

   task automatic test_signed();
      run_op("div_m7_2", 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 6'd8, 0);
      run_op("rem_m7_2", 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 6'd9, 0);
      run_op("rem_7_m2", 1'b1, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 6'd10, 0);
      run_op("div_7_m2", 1'b0, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 6'd11, 0);
   endtask

   task automatic test_div_zero();
      run_op("div_zero",  1'b0, 1'b1, 1'b1, 32'h1234_5678, 32'd0, 6'd12, 0);
      run_op("remu_zero", 1'b1, 1'b0, 1'b0, 32'd5, 32'd0, 6'd13, 0);
      run_op("rem_zero",  1'b1, 1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, 6'd14, 0);
   endtask

   task automatic test_overflow();
      run_op("div_ovf", 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 6'd15, 0);
      run_op("rem_ovf", 1'b1, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 6'd16, 0);
   endtask

   task automatic test_kill();
      int n;
      issue(1'b0, 1'b0, 1'b0, 32'd1000, 32'd7, 6'd20, 1'b0);
      repeat (9) @(negedge clk);
      kill = 1'b1;
      @(posedge clk);
      @(negedge clk);
      kill = 1'b0;
      n_tests++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL kill_busy: resp_valid=%b req_ready=%b, required 0 1", resp_valid, req_ready);
      end
      watch_quiet("kill_busy", 40);
      run_op("after_kill", 1'b0, 1'b0, 1'b0, 32'd9, 32'd3, 6'd21, 0);

      req_valid = 1'b1; req_src1 = 32'd9; req_src2 = 32'd3; req_tag = 6'd22;
      req_op = MD_OP_DIV; req_out_sel = MD_OUT_LO; kill = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; kill = 1'b0;
      n_tests++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL kill_idle_accept: req_ready=%b, required 1", req_ready);
      end
      watch_quiet("kill_idle", 40);

      issue(1'b0, 1'b0, 1'b0, 32'd100, 32'd7, 6'd23, 1'b0);
      n = 0;
      while (resp_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      kill = 1'b1;
      @(posedge clk);
      @(negedge clk);
      kill = 1'b0;
      n_tests++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL kill_done: resp_valid=%b req_ready=%b, required 0 1", resp_valid, req_ready);
      end
   endtask

   task automatic test_backpressure();
      run_op("backpressure", 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_1234, 6'h2A, 20);
   endtask

   task automatic test_back_to_back();
      logic [XLEN-1:0] a, b;
      logic s, want_rem;
      for (int i = 0; i < 10; i++) begin
         a = $urandom();
         b = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom() : 32'($urandom_range(1, 100)));
         s = 1'($urandom_range(0, 1));
         want_rem = 1'($urandom_range(0, 1));
         run_op($sformatf("rand%0d", i), want_rem, s, s, a, b, 6'($urandom_range(0, 63)), 0);
      end
   endtask

   task automatic test_async_reset();
      issue(1'b0, 1'b1, 1'b1, 32'hFFFF_0000, 32'd3, 6'd33, 1'b0);
      repeat (5) @(negedge clk);
      #2;
      reset_x = 1'b0;
      #1;
      n_tests++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_result !== '0 || resp_tag !== '0) begin
         n_fail++;
         $display("FAIL async_reset: ready=%b valid=%b result=0x%08h tag=%0d, required 1 0 0 0",
                  req_ready, resp_valid, resp_result, resp_tag);
      end
      @(negedge clk);
      reset_x = 1'b1;
      @(negedge clk);
      run_op("after_reset", 1'b0, 1'b0, 1'b0, 32'd100, 32'd7, 6'd5, 0);
   endtask

   // ---------------- main sequence and report ----------------
   initial begin
      req_valid       = 1'b0;
      req_op          = MD_OP_DIV;
      req_in_1_signed = 1'b0;
      req_in_2_signed = 1'b0;
      req_out_sel     = MD_OUT_LO;
      req_src1        = '0;
      req_src2        = '0;
      req_tag         = '0;
      kill            = 1'b0;
      resp_ready      = 1'b0;
      reset_x         = 1'b0;
      @(negedge clk);
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_overflow();
      test_kill();
      test_backpressure();
      test_back_to_back();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
